// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types, constants and helper functions for the LC-3b
//                pipeline control unit (pipe_ctrl) and its forwarding matcher.
//                Optional feature macro used by pipe_ctrl: PIPE_CTRL_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // LC-3b has eight architectural registers.
    localparam int LC3B_REG_W = 3;

    typedef logic [LC3B_REG_W-1:0] lc3b_reg;

    // One scoreboard entry: what an in-flight instruction will write back.
    typedef struct packed {
        logic    valid;
        logic    wr;
        logic    is_load;
        lc3b_reg dest;
    } pipe_slot_t;

    // Forwarding select value meaning "use the ID/EX register operand".
    localparam int FWD_REGFILE = 0;

    // True when an entry is a live producer of register r.
    function automatic logic dest_hit(input logic    valid,
                                      input logic    wr,
                                      input lc3b_reg dest,
                                      input lc3b_reg r);
        return valid & wr & (dest == r);
    endfunction

    // 32-bit counter increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_fwd_match
//  Description : Forwarding select for one EX source operand. Scans the
//                downstream scoreboard slots (1 = MEM .. FWD_STAGES = WB) and
//                returns the index of the youngest live producer of the
//                operand, or FWD_REGFILE when none exists.
//  Ports       : src        - EX source register
//                src_used   - operand is actually read
//                slot_valid - per downstream slot: holds a real instruction
//                slot_wr    - per downstream slot: writes the regfile
//                slot_dest  - per downstream slot: destination register
//                sel        - forwarding select for this operand
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
    input  lc3b_reg                   src,
    input  logic                      src_used,
    input  logic    [FWD_STAGES:1]    slot_valid,
    input  logic    [FWD_STAGES:1]    slot_wr,
    input  lc3b_reg [FWD_STAGES:1]    slot_dest,
    output logic    [FWD_SEL_W-1:0]   sel
);

    // Scan oldest to youngest so the last hit, i.e. the youngest producer,
    // is the one that sticks.
    always_comb begin
        sel = FWD_SEL_W'(FWD_REGFILE);
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (src_used && dest_hit(slot_valid[k], slot_wr[k], slot_dest[k], src)) begin
                sel = FWD_SEL_W'(k);
            end
        end
    end

endmodule : pipe_ctrl_fwd_match
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline control unit for the LC-3b in-order pipeline.
//                Shadows the EX stage and FWD_STAGES downstream stages in a
//                scoreboard and derives stage-register load enables, load-use
//                bubbles, redirect flushes and EX forwarding selects.
//                Optional macro PIPE_CTRL_PERF_EN adds saturating 32-bit
//                performance counters.
//  Ports       : clk, reset (async, active-low)
//                id_*        - ID-stage instruction summary
//                mem_busy    - cache access outstanding, freezes everything
//                redirect    - taken control transfer resolved (1-cycle)
//                advance     - load enable for EX and later stage registers
//                load_if_id  - load enable for PC and IF/ID
//                bubble_ex   - ID/EX loads a NOP
//                flush_id    - IF/ID loads a NOP
//                fwd_sel     - per-operand EX forwarding select
//                perf_*      - (PIPE_CTRL_PERF_EN only) event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 3,
    parameter int FWD_STAGES = 2,
    parameter int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            id_valid,
    input  logic                            id_wr,
    input  logic                            id_is_load,
    input  logic [REG_ADDR_W-1:0]           id_dest,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]              id_src_used,
    input  logic                            mem_busy,
    input  logic                            redirect,
    output logic                            advance,
    output logic                            load_if_id,
    output logic                            bubble_ex,
    output logic                            flush_id,
    output logic [NUM_SRC*FWD_SEL_W-1:0]    fwd_sel
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]                     perf_stall_cyc,
    output logic [31:0]                     perf_bubble_cnt,
    output logic [31:0]                     perf_flush_cnt
`endif
);

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    // Slot 0 (EX) keeps the full entry plus its source operands.
    pipe_slot_t                 ex_q;
    lc3b_reg [NUM_SRC-1:0]      ex_src;
    logic    [NUM_SRC-1:0]      ex_src_used;

    // Downstream slots only need what forwarding looks at; is_load matters
    // solely for the load-use check against EX.
    logic    [FWD_STAGES:1]     dn_valid;
    logic    [FWD_STAGES:1]     dn_wr;
    lc3b_reg [FWD_STAGES:1]     dn_dest;

    // A redirect seen during a freeze, still waiting to be applied.
    logic                       pending_flush;

    logic                       load_use;
    logic                       flush_eff;
    logic                       kill_slot0;

    // ------------------------------------------------------------------
    // Hazard detection and stage enables
    // ------------------------------------------------------------------
    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] &&
                dest_hit(ex_q.valid, ex_q.wr, ex_q.dest,
                         lc3b_reg'(id_src[i*REG_ADDR_W +: REG_ADDR_W]))) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use & id_valid & ex_q.is_load;
    end

    assign flush_eff  = redirect | pending_flush;

    // Gating with reset keeps every enable low while reset is held.
    assign advance    = reset & ~mem_busy;
    // A flush overrides the load-use hold so the redirected PC is taken.
    assign load_if_id = advance & (~load_use | flush_eff);
    // The flush kills the consumer anyway, so no bubble is needed then.
    assign bubble_ex  = advance & load_use & ~flush_eff;
    assign flush_id   = advance & flush_eff;
    assign kill_slot0 = bubble_ex | flush_id;

    // ------------------------------------------------------------------
    // Scoreboard update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q          <= '0;
            ex_src        <= '0;
            ex_src_used   <= '0;
            dn_valid      <= '0;
            dn_wr         <= '0;
            dn_dest       <= '0;
            pending_flush <= 1'b0;
        end else begin
            if (mem_busy) begin
                pending_flush <= pending_flush | redirect;
            end else begin
                pending_flush <= 1'b0;
            end

            if (advance) begin
                for (int k = FWD_STAGES; k >= 2; k--) begin
                    dn_valid[k] <= dn_valid[k-1];
                    dn_wr[k]    <= dn_wr[k-1];
                    dn_dest[k]  <= dn_dest[k-1];
                end
                dn_valid[1] <= ex_q.valid;
                dn_wr[1]    <= ex_q.wr;
                dn_dest[1]  <= ex_q.dest;

                if (kill_slot0) begin
                    ex_q        <= '0;
                    ex_src      <= '0;
                    ex_src_used <= '0;
                end else begin
                    ex_q.valid   <= id_valid;
                    ex_q.wr      <= id_wr;
                    ex_q.is_load <= id_is_load;
                    ex_q.dest    <= lc3b_reg'(id_dest);
                    for (int i = 0; i < NUM_SRC; i++) begin
                        ex_src[i] <= lc3b_reg'(id_src[i*REG_ADDR_W +: REG_ADDR_W]);
                    end
                    ex_src_used  <= id_src_used;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects, one matcher per EX operand
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
            pipe_ctrl_fwd_match #(
                .FWD_STAGES (FWD_STAGES),
                .FWD_SEL_W  (FWD_SEL_W)
            ) u_fwd_match (
                .src        (ex_src[g]),
                .src_used   (ex_src_used[g]),
                .slot_valid (dn_valid),
                .slot_wr    (dn_wr),
                .slot_dest  (dn_dest),
                .sel        (fwd_sel[g*FWD_SEL_W +: FWD_SEL_W])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cyc  <= '0;
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (mem_busy) begin
                perf_stall_cyc <= sat_inc32(perf_stall_cyc);
            end
            if (bubble_ex) begin
                perf_bubble_cnt <= sat_inc32(perf_bubble_cnt);
            end
            if (flush_id) begin
                perf_flush_cnt <= sat_inc32(perf_flush_cnt);
            end
        end
    end
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl. Directed pipeline
//                scenarios followed by randomized traffic, all compared with
//                an instruction-level model of the pipeline. Honours
//                PIPE_CTRL_PERF_EN for the counter ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int NS = 2;
    localparam int FS = 2;
    localparam int RW = 3;
    localparam int SW = 2;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic              id_wr;
    logic              id_is_load;
    logic [RW-1:0]     id_dest;
    logic [NS*RW-1:0]  id_src;
    logic [NS-1:0]     id_src_used;
    logic              mem_busy;
    logic              redirect;
    logic              advance;
    logic              load_if_id;
    logic              bubble_ex;
    logic              flush_id;
    logic [NS*SW-1:0]  fwd_sel;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       perf_stall_cyc;
    logic [31:0]       perf_bubble_cnt;
    logic [31:0]       perf_flush_cnt;
`endif

    pipe_ctrl #(
        .NUM_SRC    (NS),
        .REG_ADDR_W (RW),
        .FWD_STAGES (FS),
        .FWD_SEL_W  (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_wr       (id_wr),
        .id_is_load  (id_is_load),
        .id_dest     (id_dest),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .mem_busy    (mem_busy),
        .redirect    (redirect),
        .advance     (advance),
        .load_if_id  (load_if_id),
        .bubble_ex   (bubble_ex),
        .flush_id    (flush_id),
        .fwd_sel     (fwd_sel)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: the instructions sitting in EX (index 0) .. WB.
    // ------------------------------------------------------------------
    bit          m_v   [0:FS];
    bit          m_wr  [0:FS];
    bit [RW-1:0] m_dst [0:FS];
    bit          m_ld;               // EX instruction is a load
    bit [RW-1:0] m_src [0:NS-1];     // EX instruction's operands
    bit          m_use [0:NS-1];
    bit          m_pend;             // redirect waiting for the freeze to end
    int unsigned m_stall, m_bub, m_fl;

    typedef struct packed {
        logic          adv;
        logic          lif;
        logic          bub;
        logic          fl;
        logic [NS*SW-1:0] fwd;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        bit   lu;
        bit   fe;
        int   sel;
        e = '0;
        if (!reset) return e;
        // Does the ID instruction need the value a load in EX has not yet fetched?
        lu = 1'b0;
        for (int i = 0; i < NS; i++)
            if (id_valid && m_v[0] && m_wr[0] && m_ld && id_src_used[i] &&
                id_src[i*RW +: RW] == m_dst[0]) lu = 1'b1;
        fe    = redirect | m_pend;
        e.adv = !mem_busy;
        e.lif = !mem_busy && (!lu || fe);
        e.bub = !mem_busy && lu && !fe;
        e.fl  = !mem_busy && fe;
        // Nearest older instruction that writes the operand supplies it.
        for (int i = 0; i < NS; i++) begin
            sel = 0;
            for (int k = 1; k <= FS; k++)
                if (sel == 0 && m_use[i] && m_v[k] && m_wr[k] && m_dst[k] == m_src[i]) sel = k;
            e.fwd[i*SW +: SW] = SW'(sel);
        end
        return e;
    endfunction

    exp_t upd_e;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= FS; k++) begin
                m_v[k] = 1'b0; m_wr[k] = 1'b0; m_dst[k] = '0;
            end
            m_ld = 1'b0;
            for (int i = 0; i < NS; i++) begin
                m_src[i] = '0; m_use[i] = 1'b0;
            end
            m_pend = 1'b0; m_stall = 0; m_bub = 0; m_fl = 0;
        end else begin
            upd_e = expect_now();
            if (mem_busy) begin
                m_stall++;
                m_pend = m_pend | redirect;
            end else begin
                if (upd_e.bub) m_bub++;
                if (upd_e.fl)  m_fl++;
                for (int k = FS; k >= 1; k--) begin
                    m_v[k] = m_v[k-1]; m_wr[k] = m_wr[k-1]; m_dst[k] = m_dst[k-1];
                end
                if (upd_e.bub || upd_e.fl) begin
                    m_v[0] = 1'b0; m_wr[0] = 1'b0; m_dst[0] = '0; m_ld = 1'b0;
                    for (int i = 0; i < NS; i++) begin
                        m_src[i] = '0; m_use[i] = 1'b0;
                    end
                end else begin
                    m_v[0] = id_valid; m_wr[0] = id_wr; m_dst[0] = id_dest; m_ld = id_is_load;
                    for (int i = 0; i < NS; i++) begin
                        m_src[i] = id_src[i*RW +: RW]; m_use[i] = id_src_used[i];
                    end
                end
                m_pend = 1'b0;
            end
        end
    end

    // One cycle: drive at the falling edge, compare just after.
    task automatic step(input bit rst, input bit v, input bit wr, input bit ld,
                        input bit [RW-1:0] dst, input bit [RW-1:0] s0, input bit [RW-1:0] s1,
                        input bit [NS-1:0] used, input bit busy, input bit rd);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        id_valid    = v;
        id_wr       = wr;
        id_is_load  = ld;
        id_dest     = dst;
        id_src      = {s1, s0};
        id_src_used = used;
        mem_busy    = busy;
        redirect    = rd;
        #1;
        e = expect_now();
        check("advance",    {31'd0, advance},    {31'd0, e.adv});
        check("load_if_id", {31'd0, load_if_id}, {31'd0, e.lif});
        check("bubble_ex",  {31'd0, bubble_ex},  {31'd0, e.bub});
        check("flush_id",   {31'd0, flush_id},   {31'd0, e.fl});
        check("fwd_sel",    32'(fwd_sel),        32'(e.fwd));
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_cyc",  perf_stall_cyc,  m_stall);
        check("perf_bubble_cnt", perf_bubble_cnt, m_bub);
        check("perf_flush_cnt",  perf_flush_cnt,  m_fl);
`endif
    endtask

    task automatic nop(input bit busy, input bit rd);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, busy, rd);
    endtask

    initial begin
        reset = 1'b0; id_valid = 1'b0; id_wr = 1'b0; id_is_load = 1'b0;
        id_dest = '0; id_src = '0; id_src_used = '0; mem_busy = 1'b0; redirect = 1'b0;

        // Reset held: every output must be zero even with live-looking inputs.
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 3'd4, 2'b11, 1'b0, 1'b0);
        check("rst_advance", {31'd0, advance}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // ALU producer forwarding from MEM, then from WB.
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);   // ADD R1
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 3'd1, 3'd3, 2'b11, 1'b0, 1'b0);   // ADD R2,R1,R3
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 3'd1, 3'd0, 2'b01, 1'b0, 1'b0);   // reader of R1
        check("tp1_fwd0_mem", 32'(fwd_sel[1:0]), 32'd1);
        check("tp1_fwd1_rf",  32'(fwd_sel[3:2]), 32'd0);
        nop(1'b0, 1'b0);
        check("tp1_fwd0_wb",  32'(fwd_sel[1:0]), 32'd2);

        // Load-use: one bubble, then the load result forwards from WB.
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);   // LDR R4
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd4, 3'd0, 2'b01, 1'b0, 1'b0);
        check("tp2_bubble", {31'd0, bubble_ex},  32'd1);
        check("tp2_hold",   {31'd0, load_if_id}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd4, 3'd0, 2'b01, 1'b0, 1'b0);
        check("tp2_release", {31'd0, load_if_id}, 32'd1);
        nop(1'b0, 1'b0);
        check("tp2_fwd_wb", 32'(fwd_sel[1:0]), 32'd2);

        // Load-use under a 3-cycle freeze.
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd4, 3'd0, 2'b01, 1'b1, 1'b0);
            check("tp3_frozen_adv", {31'd0, advance},   32'd0);
            check("tp3_frozen_bub", {31'd0, bubble_ex}, 32'd0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd4, 3'd0, 2'b01, 1'b0, 1'b0);
        check("tp3_late_bubble", {31'd0, bubble_ex}, 32'd1);

        // Redirect during a freeze is held and applied once on release.
        nop(1'b1, 1'b1);
        check("tp4_busy_flush0", {31'd0, flush_id}, 32'd0);
        nop(1'b1, 1'b0);
        check("tp4_busy_flush1", {31'd0, flush_id}, 32'd0);
        nop(1'b0, 1'b0);
        check("tp4_release_flush", {31'd0, flush_id}, 32'd1);
        nop(1'b0, 1'b0);
        check("tp4_pending_clr", {31'd0, flush_id}, 32'd0);

        // Redirect beats load-use.
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd4, 3'd0, 2'b01, 1'b0, 1'b1);
        check("tp5_flush", {31'd0, flush_id},   32'd1);
        check("tp5_nobub", {31'd0, bubble_ex},  32'd0);
        check("tp5_pc",    {31'd0, load_if_id}, 32'd1);

        // Two producers of R5: the younger one wins.
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 3'd0, 2'b01, 1'b0, 1'b0);
        nop(1'b0, 1'b0);
        check("tp6_youngest", 32'(fwd_sel[1:0]), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
        check("tp_perf_bubbles", perf_bubble_cnt, 32'd2);
        check("tp_perf_flushes", perf_flush_cnt,  32'd2);
`endif

        // Randomized traffic on a small register set to provoke hazards,
        // with one asynchronous reset in the middle.
        for (int n = 0; n < 400; n++) begin
            step((n >= 200 && n < 203) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
